// File: rtl/npu_out_pkg.sv
// Shared types, default geometry and width helpers for the NPU output packing stage.
package npu_out_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DRAIN     = 2'd1,
        WAIT_BANK = 2'd2
    } state_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_PACK        = 2;
    localparam int FRAME_WIDTH     = 640;
    localparam int FRAME_HEIGHT    = 480;
    localparam int DEF_FRAME_LINES = FRAME_WIDTH * FRAME_HEIGHT / DEF_PACK;
    localparam int DEF_ADDR_W      = 18;

    // Bits needed to hold the value n itself (counters that reach their limit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index 0..n-1.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lane_assembler.sv
// Collects PACK consecutive words into one line (lane 0 in the LSBs) and
// emits the finished line together with a one-cycle valid pulse.
module lane_assembler
    import npu_out_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK   = DEF_PACK
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   word_valid_i,
    input  logic [DATA_W-1:0]      word_i,
    output logic                   line_valid_o,
    output logic [DATA_W*PACK-1:0] line_o
);

    logic                   line_valid_q;
    logic [DATA_W*PACK-1:0] line_q;

    generate
        if (PACK == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_valid_q <= 1'b0;
                    line_q       <= '0;
                end else begin
                    line_valid_q <= word_valid_i;
                    if (word_valid_i) begin
                        line_q <= word_i;
                    end
                end
            end
        end else begin : g_multi
            localparam int LANE_W = idx_w(PACK);

            logic [LANE_W-1:0]          lane_idx_q;
            logic [DATA_W*(PACK-1)-1:0] asm_q;

            // NOTE: the assembly register is reset too, so a line cut short by reset never leaks into the next one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_valid_q <= 1'b0;
                    line_q       <= '0;
                    lane_idx_q   <= '0;
                    asm_q        <= '0;
                end else begin
                    line_valid_q <= 1'b0;
                    if (word_valid_i) begin
                        if (lane_idx_q == LANE_W'(PACK - 1)) begin
                            line_q       <= {word_i, asm_q};
                            line_valid_q <= 1'b1;
                            lane_idx_q   <= '0;
                        end else begin
                            for (int l = 0; l < PACK - 1; l++) begin
                                if (lane_idx_q == LANE_W'(l)) begin
                                    asm_q[l*DATA_W +: DATA_W] <= word_i;
                                end
                            end
                            lane_idx_q <= lane_idx_q + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign line_valid_o = line_valid_q;
    assign line_o       = line_q;

endmodule

// File: rtl/output_pingpong_packer.sv
// Drains the NPU output FIFO, packs words into RAM lines and fills two RAM
// banks alternately, handing each complete frame to the reader via frame_ready.
module output_pingpong_packer
    import npu_out_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PACK        = DEF_PACK,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   output_fifo_empty,
    input  logic [DATA_W-1:0]      output_data,
    output logic                   output_fifo_read_enable,
    output logic                   ram_we,
    output logic [ADDR_W:0]        ram_waddr,
    output logic [DATA_W*PACK-1:0] ram_wdata,
    input  logic [1:0]             frame_ack,
    output logic [1:0]             frame_ready,
    output logic [15:0]            frame_count,
    output logic                   busy
);

    localparam int TOTAL_WORDS = FRAME_LINES * PACK;
    localparam int REQ_W       = cnt_w(TOTAL_WORDS);

    state_e                 state_q, state_d;
    logic [REQ_W-1:0]       req_cnt_q, req_cnt_d;
    logic [ADDR_W-1:0]      line_idx_q, line_idx_d;
    logic                   bank_q, bank_d;
    logic [1:0]             frame_ready_q, frame_ready_d;
    logic [15:0]            frame_count_q;
    logic                   rd_v_q;
    logic                   pop;
    logic                   line_valid;
    logic                   last_line;
    logic [DATA_W*PACK-1:0] line_data;

    lane_assembler #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_lane_assembler (
        .clk          (clk),
        .rst_n        (reset),
        .word_valid_i (rd_v_q),
        .word_i       (output_data),
        .line_valid_o (line_valid),
        .line_o       (line_data)
    );

    assign last_line = line_valid && (line_idx_q == ADDR_W'(FRAME_LINES - 1));

    // NOTE: every signal gets its default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        req_cnt_d     = req_cnt_q;
        line_idx_d    = line_idx_q;
        bank_d        = bank_q;
        frame_ready_d = frame_ready_q & ~frame_ack;
        pop           = 1'b0;

        if (line_valid) begin
            line_idx_d = line_idx_q + 1'b1;
        end

        unique case (state_q)
            FILL: begin
                // Gated by reset so the pop request drops the moment reset asserts.
                pop = reset && !output_fifo_empty && (req_cnt_q < REQ_W'(TOTAL_WORDS));
                if (pop) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                    if (req_cnt_q == REQ_W'(TOTAL_WORDS - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_line) begin
                    frame_ready_d[bank_q] = 1'b1;
                    bank_d                = ~bank_q;
                    req_cnt_d             = '0;
                    line_idx_d            = '0;
                    state_d = (frame_ready_q[~bank_q] && !frame_ack[~bank_q]) ? WAIT_BANK : FILL;
                end
            end
            WAIT_BANK: begin
                if (frame_ack[bank_q]) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FILL;
            req_cnt_q     <= '0;
            line_idx_q    <= '0;
            bank_q        <= 1'b0;
            frame_ready_q <= '0;
            frame_count_q <= '0;
            rd_v_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_cnt_q     <= req_cnt_d;
            line_idx_q    <= line_idx_d;
            bank_q        <= bank_d;
            frame_ready_q <= frame_ready_d;
            rd_v_q        <= pop;
            if (last_line) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign output_fifo_read_enable = pop;
    assign ram_we                  = line_valid;
    assign ram_waddr               = {bank_q, line_idx_q};
    assign ram_wdata               = line_data;
    assign frame_ready             = frame_ready_q;
    assign frame_count             = frame_count_q;
    assign busy                    = (state_q != FILL) || rd_v_q;

endmodule

// File: tb/tb_output_pingpong_packer.sv
// Bench for output_pingpong_packer: a FIFO/reader model drives the block and a
// word-stream reference predicts every RAM line, address, flag and counter.
module tb_output_pingpong_packer;
    import npu_out_pkg::*;

    localparam int DW  = 32;
    localparam int P   = 2;
    localparam int AW  = 2;
    localparam int FL  = 4;
    localparam int DW1 = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance: PACK=2, 4-line frames
    logic            empty;
    logic [DW-1:0]   odata;
    logic            rd_en, we, busy;
    logic [AW:0]     waddr;
    logic [DW*P-1:0] wdata;
    logic [1:0]      ack, ready;
    logic [15:0]     fcount;

    // Second instance: PACK=1, 16-bit words
    logic            e1;
    logic [DW1-1:0]  d1data;
    logic            rd1, we1, busy1;
    logic [AW:0]     wa1;
    logic [DW1-1:0]  wd1;
    logic [1:0]      ack1, rdy1;
    logic [15:0]     cnt1;

    output_pingpong_packer #(.DATA_W(DW), .PACK(P), .ADDR_W(AW), .FRAME_LINES(FL)) dut (
        .clk(clk), .reset(reset), .output_fifo_empty(empty), .output_data(odata),
        .output_fifo_read_enable(rd_en), .ram_we(we), .ram_waddr(waddr), .ram_wdata(wdata),
        .frame_ack(ack), .frame_ready(ready), .frame_count(fcount), .busy(busy)
    );

    output_pingpong_packer #(.DATA_W(DW1), .PACK(1), .ADDR_W(AW), .FRAME_LINES(FL)) dut1 (
        .clk(clk), .reset(reset), .output_fifo_empty(e1), .output_data(d1data),
        .output_fifo_read_enable(rd1), .ram_we(we1), .ram_waddr(wa1), .ram_wdata(wd1),
        .frame_ack(ack1), .frame_ready(rdy1), .frame_count(cnt1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [DW-1:0] src[$];
    logic [DW-1:0] popped[$];
    int            popped_cyc[$];
    int            n_pops, n_lines, last_pop_cyc;
    int            pop_cyc_arr[256];
    int            we_cyc_arr[256];
    logic [1:0]    exp_ready, set_pend, manual_ack;
    logic [15:0]   exp_count;
    int            cnt_pend;
    logic [DW-1:0] pend_w;
    bit            pend_v, auto_ack, rand_empty;
    logic [DW*P-1:0] last_wdata;
    logic [AW:0]     last_waddr;

    task automatic clear_model();
        popped.delete();
        popped_cyc.delete();
        n_pops = 0; n_lines = 0; last_pop_cyc = 0;
        exp_ready = '0; set_pend = '0; manual_ack = '0;
        exp_count = '0; cnt_pend = 0;
        pend_v = 0; auto_ack = 0; rand_empty = 0;
    endtask

    // One clock: drive inputs after the edge, then judge outputs at the falling edge.
    task automatic tick();
        logic [DW*P-1:0] exp_data;
        logic [AW:0]     exp_addr;
        logic [DW-1:0]   w;
        int              frame;
        @(posedge clk);
        cyc++;
        #1;
        exp_ready = (exp_ready & ~ack) | set_pend;
        exp_count = exp_count + 16'(cnt_pend);
        set_pend  = '0;
        cnt_pend  = 0;
        odata     = pend_v ? pend_w : DW'($urandom);
        pend_v    = 0;
        empty     = (src.size() == 0) || (rand_empty && ($urandom_range(99) < 40));
        ack       = auto_ack ? (exp_ready & 2'($urandom_range(3))) : manual_ack;
        manual_ack = '0;
        @(negedge clk);
        checks += 2;
        if (ready !== exp_ready) begin
            errors++;
            $display("FAIL frame_ready cycle %0d: got %b expected %b", cyc, ready, exp_ready);
        end
        if (fcount !== exp_count) begin
            errors++;
            $display("FAIL frame_count cycle %0d: got %0d expected %0d", cyc, fcount, exp_count);
        end
        if (rd_en === 1'b1) begin
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL pop_while_empty cycle %0d: read_enable 1 expected 0", cyc);
            end else begin
                w = src.pop_front();
                popped.push_back(w);
                popped_cyc.push_back(cyc);
                if (n_pops < 256) pop_cyc_arr[n_pops] = cyc;
                n_pops++;
                last_pop_cyc = cyc;
                pend_w = w;
                pend_v = 1;
            end
        end
        if (we === 1'b1) begin
            frame = n_lines / FL;
            checks += 3;
            if (popped.size() < P) begin
                errors++;
                $display("FAIL line_without_words cycle %0d: got %0d words expected %0d", cyc, popped.size(), P);
            end else begin
                for (int j = 0; j < P; j++) exp_data[j*DW +: DW] = popped[j];
                exp_addr = (AW+1)'((frame % 2) * FL + n_lines % FL);
                if (wdata !== exp_data) begin
                    errors++;
                    $display("FAIL line_data line %0d: got %h expected %h", n_lines, wdata, exp_data);
                end
                if (waddr !== exp_addr) begin
                    errors++;
                    $display("FAIL line_addr line %0d: got %0d expected %0d", n_lines, waddr, exp_addr);
                end
                if (cyc - popped_cyc[P-1] != 2) begin
                    errors++;
                    $display("FAIL line_latency line %0d: got %0d expected 2", n_lines, cyc - popped_cyc[P-1]);
                end
                for (int j = 0; j < P; j++) begin
                    void'(popped.pop_front());
                    void'(popped_cyc.pop_front());
                end
            end
            last_wdata = wdata;
            last_waddr = waddr;
            if (n_lines < 256) we_cyc_arr[n_lines] = cyc;
            if (n_lines % FL == FL - 1) begin
                set_pend[frame % 2] = 1'b1;
                cnt_pend = 1;
            end
            n_lines++;
        end
    endtask

    task automatic run_lines(input int target, input int budget, input string tag);
        int n = 0;
        while (n_lines < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n_lines < target) begin
            errors++;
            $display("FAIL %s timeout: got %0d lines expected %0d", tag, n_lines, target);
        end
    endtask

    task automatic run_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (n_pops < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n_pops < target) begin
            errors++;
            $display("FAIL %s timeout: got %0d pops expected %0d", tag, n_pops, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        empty = 1'b1;
        ack   = '0;
        odata = '0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        // FIFO non-empty while in reset: the pop request must still be 0.
        empty = 1'b0;
        #12;
        checks++;
        if ({rd_en, we, waddr, wdata, ready, fcount, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {rd_en, we, waddr, wdata, ready, fcount, busy});
        end
        @(negedge clk);
        empty = 1'b1;
        clear_model();
        reset = 1'b1;
        src.delete();
        for (int i = 0; i < 11; i++) src.push_back(DW'($urandom));
        run_pops(3, 50, "reset_prefill");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rd_en, we, waddr, wdata, ready, fcount, busy} !== '0) begin
            errors++;
            $display("FAIL reset_midline: got %h expected 0", {rd_en, we, waddr, wdata, ready, fcount, busy});
        end
        empty = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_lines(4, 100, "reset_fresh");
        tick();
        checks += 3;
        if (n_pops != 8) begin
            errors++;
            $display("FAIL reset_fresh_pops: got %0d expected 8", n_pops);
        end
        if (last_waddr !== 3'b011) begin
            errors++;
            $display("FAIL reset_fresh_last_addr: got %0d expected 3", last_waddr);
        end
        if (ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_fresh_ready: got %b expected 01", ready);
        end
    endtask

    task automatic test_packing();
        do_reset();
        src.delete();
        src.push_back(32'h11111111);
        src.push_back(32'h22222222);
        run_lines(1, 50, "packing");
        checks += 3;
        if (last_wdata !== 64'h22222222_11111111) begin
            errors++;
            $display("FAIL packing_data: got %h expected 2222222211111111", last_wdata);
        end
        if (last_waddr !== '0) begin
            errors++;
            $display("FAIL packing_addr: got %0d expected 0", last_waddr);
        end
        if (we_cyc_arr[0] - pop_cyc_arr[1] != 2) begin
            errors++;
            $display("FAIL packing_latency: got %0d expected 2", we_cyc_arr[0] - pop_cyc_arr[1]);
        end
    endtask

    task automatic test_pingpong();
        do_reset();
        src.delete();
        for (int i = 0; i < 24; i++) src.push_back(DW'($urandom));
        run_lines(8, 200, "pingpong");
        repeat (8) tick();
        checks += 7;
        if (ready !== 2'b11) begin
            errors++;
            $display("FAIL pingpong_ready: got %b expected 11", ready);
        end
        if (fcount !== 16'd2) begin
            errors++;
            $display("FAIL pingpong_count: got %0d expected 2", fcount);
        end
        if (dut.state_q !== WAIT_BANK) begin
            errors++;
            $display("FAIL pingpong_state: got %0d expected %0d", dut.state_q, WAIT_BANK);
        end
        if (n_pops != 16 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_stall: got %0d pops rd %b expected 16 pops rd 0", n_pops, rd_en);
        end
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_fifo_state: got empty %b expected 0", empty);
        end
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pingpong_busy: got %b expected 1", busy);
        end
        if (pop_cyc_arr[8] - we_cyc_arr[3] != 1) begin
            errors++;
            $display("FAIL frame_switch_bubble: got %0d expected 1", pop_cyc_arr[8] - we_cyc_arr[3]);
        end
    endtask

    task automatic test_release();
        int ack_cyc;
        manual_ack = 2'b01;
        tick();
        ack_cyc = cyc;
        tick();
        checks++;
        if (n_pops != 17 || last_pop_cyc != ack_cyc + 1) begin
            errors++;
            $display("FAIL release_resume: got pops %0d at cycle %0d expected 17 at %0d", n_pops, last_pop_cyc, ack_cyc + 1);
        end
        run_lines(9, 50, "release_first_line");
        checks++;
        if (last_waddr !== '0) begin
            errors++;
            $display("FAIL release_addr: got %0d expected 0", last_waddr);
        end
        run_lines(12, 100, "release_frame");
        repeat (4) tick();
        checks++;
        if (dut.state_q !== WAIT_BANK || ready !== 2'b11) begin
            errors++;
            $display("FAIL release_wait: got state %0d ready %b expected %0d 11", dut.state_q, ready, WAIT_BANK);
        end
        manual_ack = 2'b10;
        tick();
        tick();
        manual_ack = 2'b10;
        tick();
        repeat (3) tick();
        checks += 2;
        if (ready !== 2'b01) begin
            errors++;
            $display("FAIL ack_not_ready: got %b expected 01", ready);
        end
        if (dut.state_q !== FILL || fcount !== 16'd3) begin
            errors++;
            $display("FAIL ack_release_state: got state %0d count %0d expected %0d 3", dut.state_q, fcount, FILL);
        end
    endtask

    task automatic test_bursty();
        do_reset();
        src.delete();
        for (int i = 0; i < 24; i++) src.push_back(DW'($urandom));
        rand_empty = 1;
        auto_ack   = 1;
        run_lines(12, 3000, "bursty");
        repeat (3) tick();
        rand_empty = 0;
        auto_ack   = 0;
        checks += 3;
        if (n_pops != 24 || src.size() != 0) begin
            errors++;
            $display("FAIL bursty_pops: got %0d pops %0d left expected 24 0", n_pops, src.size());
        end
        if (popped.size() != 0 || n_lines != 12) begin
            errors++;
            $display("FAIL bursty_lines: got %0d lines %0d stray words expected 12 0", n_lines, popped.size());
        end
        if (fcount !== 16'd3) begin
            errors++;
            $display("FAIL bursty_count: got %0d expected 3", fcount);
        end
    endtask

    task automatic test_pack1();
        logic [DW1-1:0] src1[$];
        logic [DW1-1:0] got1[$];
        int             got_cyc[$];
        logic [DW1-1:0] pw;
        logic [AW:0]    exp_a;
        bit             pv = 0;
        bit             wrap_seen = 0;
        int             k1 = 0;
        int             n = 0;
        do_reset();
        @(negedge clk);
        force dut1.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut1.frame_count_q;
        @(negedge clk);
        checks++;
        if (cnt1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL pack1_preload: got %h expected ffff", cnt1);
        end
        for (int i = 0; i < 8; i++) src1.push_back(DW1'($urandom));
        while (k1 < 8 && n < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (pv) d1data = pw;
            pv   = 0;
            ack1 = rdy1;
            e1   = (src1.size() == 0);
            @(negedge clk);
            n++;
            if (k1 == 4 && !wrap_seen) begin
                wrap_seen = 1;
                checks++;
                if (cnt1 !== 16'h0000) begin
                    errors++;
                    $display("FAIL pack1_wrap: got %h expected 0000", cnt1);
                end
            end
            if (rd1 === 1'b1 && src1.size() != 0) begin
                pw = src1.pop_front();
                got1.push_back(pw);
                got_cyc.push_back(cyc);
                pv = 1;
            end
            if (we1 === 1'b1) begin
                checks += 3;
                exp_a = (AW+1)'(((k1 / FL) % 2) * FL + k1 % FL);
                if (got1.size() == 0) begin
                    errors++;
                    $display("FAIL pack1_line_without_word line %0d: got 0 words expected 1", k1);
                end else begin
                    if (wd1 !== got1[0]) begin
                        errors++;
                        $display("FAIL pack1_data line %0d: got %h expected %h", k1, wd1, got1[0]);
                    end
                    if (wa1 !== exp_a) begin
                        errors++;
                        $display("FAIL pack1_addr line %0d: got %0d expected %0d", k1, wa1, exp_a);
                    end
                    if (cyc - got_cyc[0] != 2) begin
                        errors++;
                        $display("FAIL pack1_latency line %0d: got %0d expected 2", k1, cyc - got_cyc[0]);
                    end
                    void'(got1.pop_front());
                    void'(got_cyc.pop_front());
                end
                k1++;
            end
        end
        checks++;
        if (k1 < 8) begin
            errors++;
            $display("FAIL pack1 timeout: got %0d lines expected 8", k1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cnt1 !== 16'h0001) begin
            errors++;
            $display("FAIL pack1_count: got %h expected 0001", cnt1);
        end
        e1   = 1'b1;
        ack1 = '0;
    endtask

    initial begin
        reset  = 1'b0;
        empty  = 1'b1;
        odata  = '0;
        ack    = '0;
        e1     = 1'b1;
        d1data = '0;
        ack1   = '0;
        clear_model();
        test_reset();
        test_packing();
        test_pingpong();
        test_release();
        test_bursty();
        test_pack1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
